bits_to_symbols_tx: RTL

- Transmit-side counterpart of the coefficient-to-bit decoder.
- Takes an N-bit word and maps each bit to a fixed-point symbol: bit 0 → SYM_ZERO (1.0), bit 1 → SYM_ONE (2.0).
- Serialises the symbols one per cycle over a valid/ready stream for the OMP front end.
- The decoder's 1.5 threshold (192) is the midpoint of the two levels, so encode → decode is lossless.

---
 rtl/bits_to_symbols_tx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bits_to_symbols_tx.sv
// Serialises an N-bit word into fixed-point symbols (bit 0 -> SYM_ZERO, bit 1 -> SYM_ONE),
// one per cycle over valid/ready. Optional macro BITS_TO_SYMBOLS_PACKED_OUT_EN adds a packed output.
module bits_to_symbols_tx #(
    parameter int unsigned N          = 1,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int          SYM_ZERO   = 128,
    parameter int          SYM_ONE    = 256,
    parameter int unsigned IDX_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          in_bits,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] sym_data,
    output logic                  sym_valid,
    input  logic                  sym_ready,
    output logic [IDX_W-1:0]      sym_index,
    output logic                  sym_last
`ifdef BITS_TO_SYMBOLS_PACKED_OUT_EN
    ,
    output logic [N*DATA_WIDTH-1:0] sym_packed,
    output logic                    sym_packed_valid
`endif
);

    localparam logic [DATA_WIDTH-1:0] SymZero = DATA_WIDTH'(SYM_ZERO);
    localparam logic [DATA_WIDTH-1:0] SymOne  = DATA_WIDTH'(SYM_ONE);
    localparam logic [IDX_W-1:0]      LastIdx = IDX_W'(N - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                state_q, state_d;
    logic [N-1:0]          bits_q, bits_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  last_q, last_d;
    logic                  word_acc;

    function automatic logic [DATA_WIDTH-1:0] map_bit(input logic b);
        return b ? SymOne : SymZero;
    endfunction

    // bits_q is a shift register: bit 0 always holds the next symbol still to be sent.
    always_comb begin
        state_d  = state_q;
        bits_d   = bits_q;
        data_d   = data_q;
        idx_d    = idx_q;
        last_d   = last_q;
        in_ready = (state_q == StIdle) | ((state_q == StSend) & last_q & sym_ready);
        word_acc = in_valid & in_ready;

        unique case (state_q)
            StIdle: begin
                if (word_acc) begin
                    bits_d  = in_bits >> 1;
                    data_d  = map_bit(in_bits[0]);
                    idx_d   = '0;
                    last_d  = (N == 1);
                    state_d = StSend;
                end
            end
            StSend: begin
                if (sym_ready) begin
                    if (!last_q) begin
                        bits_d = bits_q >> 1;
                        data_d = map_bit(bits_q[0]);
                        idx_d  = idx_q + IDX_W'(1);
                        last_d = ((idx_q + IDX_W'(1)) == LastIdx);
                    end else if (word_acc) begin
                        bits_d = in_bits >> 1;
                        data_d = map_bit(in_bits[0]);
                        idx_d  = '0;
                        last_d = (N == 1);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            bits_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign sym_valid = (state_q == StSend);
    assign sym_data  = data_q;
    assign sym_index = idx_q;
    assign sym_last  = last_q;

`ifdef BITS_TO_SYMBOLS_PACKED_OUT_EN
    logic [N*DATA_WIDTH-1:0] packed_q, packed_d;
    logic                    packed_valid_q;

    // Symbol 0 occupies the most significant slice, matching the decoder's input layout.
    always_comb begin
        packed_d = packed_q;
        if (word_acc) begin
            for (int i = 0; i < int'(N); i++) begin
                packed_d[(int'(N) - i) * int'(DATA_WIDTH) - 1 -: DATA_WIDTH] = map_bit(in_bits[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            packed_q       <= '0;
            packed_valid_q <= 1'b0;
        end else begin
            packed_q       <= packed_d;
            packed_valid_q <= word_acc;
        end
    end

    assign sym_packed       = packed_q;
    assign sym_packed_valid = packed_valid_q;
`else
    // Serial-only build: no packed output state.
`endif

endmodule
